// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered framebuffer: default widths,
// the R7/G7/B6 pixel layout and the bank-swap state encoding.
package fb_pkg;

  localparam int R_W = 7;
  localparam int G_W = 7;
  localparam int B_W = 6;

  localparam int FB_DATA_W = R_W + G_W + B_W;
  localparam int FB_ADDR_W = 14;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VSYNC,
    SWAP,
    RELEASE
  } swap_state_t;

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: simple dual-port RAM with a write port and a registered
// read port, written so synthesis maps it onto block RAM.
module fb_bank
  import fb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-first: a read and a write to the same address on one edge
  // returns the previous contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/framebuffer.sv
// Double-buffered pixel store: the receiver fills the back bank while the
// panel scans out the front bank; banks exchange once a full frame is ready.
module framebuffer
  import fb_pkg::*;
#(
  parameter int ADDR_W        = FB_ADDR_W,
  parameter int DATA_W        = FB_DATA_W,
  parameter bit SWAP_ON_VSYNC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_en,
  input  logic              full,
  output logic              swapped,
  input  logic              frame_done,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              front_bank
);

  swap_state_t state;
  swap_state_t state_next;
  logic        swap_fire;

  logic              wr_bank;
  logic              wr_en0;
  logic              wr_en1;

  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_bank_q;
  logic              rd_en_q2;
  logic              rd_bank_q2;
  logic [DATA_W-1:0] bank0_q;
  logic [DATA_W-1:0] bank1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Outside VSYNC mode a ready frame never waits, so WAIT_VSYNC is unreachable.
  always_comb begin
    state_next = state;
    swap_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (full && (frame_done || !SWAP_ON_VSYNC)) begin
          state_next = SWAP;
        end else if (full) begin
          state_next = WAIT_VSYNC;
        end
      end
      WAIT_VSYNC: begin
        if (!full) begin
          state_next = IDLE;
        end else if (frame_done) begin
          state_next = SWAP;
        end
      end
      SWAP:    state_next = RELEASE;
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    swap_fire = (state_next == SWAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      front_bank <= 1'b0;
      swapped    <= 1'b0;
    end else begin
      swapped <= swap_fire;
      if (swap_fire) begin
        front_bank <= ~front_bank;
      end
    end
  end

  // During the swapped cycle front_bank already shows the new bank, but the
  // receiver is still finishing the old frame, so steer to the old back bank.
  assign wr_bank = swapped ? front_bank : ~front_bank;
  assign wr_en0  = wr_en & ~wr_bank;
  assign wr_en1  = wr_en &  wr_bank;

  fb_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_en0),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en_q),
    .rd_addr (rd_addr_q),
    .rd_data (bank0_q)
  );

  fb_bank #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_en1),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en_q),
    .rd_addr (rd_addr_q),
    .rd_data (bank1_q)
  );

  // The bank index travels with the address so reads in flight across a
  // swap still come from the bank that was front when they were issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_bank_q  <= 1'b0;
      rd_en_q2   <= 1'b0;
      rd_bank_q2 <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      rd_en_q <= rd_en;
      if (rd_en) begin
        rd_addr_q <= rd_addr;
        rd_bank_q <= front_bank;
      end
      rd_en_q2   <= rd_en_q;
      rd_bank_q2 <= rd_bank_q;
      rd_valid   <= rd_en_q2;
      if (rd_en_q2) begin
        rd_data <= rd_bank_q2 ? bank1_q : bank0_q;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer.sv
// Self-checking bench for framebuffer: a frame-level reference model checked
// every cycle, plus directed scenarios with hand-computed literal results.
module tb_framebuffer;

  localparam int AW    = 14;
  localparam int DW    = 20;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_en = 1'b0;
  logic          full = 1'b0;
  logic          frame_done = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic          swapped;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          front_bank;

  logic          full_nv = 1'b0;
  logic          zero_bit = 1'b0;
  logic [AW-1:0] zero_addr = '0;
  logic [DW-1:0] zero_data = '0;
  logic          swapped_nv;
  logic [DW-1:0] rd_data_nv;
  logic          rd_valid_nv;
  logic          front_bank_nv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  framebuffer #(.ADDR_W(AW), .DATA_W(DW), .SWAP_ON_VSYNC(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .full(full), .swapped(swapped), .frame_done(frame_done), .rd_addr(rd_addr),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .front_bank(front_bank)
  );

  framebuffer #(.ADDR_W(AW), .DATA_W(DW), .SWAP_ON_VSYNC(1'b0)) dut_nv (
    .clk(clk), .rst(rst), .wr_data(zero_data), .wr_addr(zero_addr), .wr_en(zero_bit),
    .full(full_nv), .swapped(swapped_nv), .frame_done(zero_bit), .rd_addr(zero_addr),
    .rd_en(zero_bit), .rd_data(rd_data_nv), .rd_valid(rd_valid_nv), .front_bank(front_bank_nv)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: two banks as plain arrays, a queue of pending reads
  // that mature two edges after issue, and a swap cooldown counter.
  typedef struct {
    int            due;
    logic [DW-1:0] val;
    bit            known;
  } rd_t;

  logic [DW-1:0] m_mem   [2][DEPTH];
  bit            m_known [2][DEPTH];
  rd_t           m_q[$];
  int            m_cycle = 0;
  int            m_hold = 0;
  bit            m_front = 1'b0;
  bit            m_swapped = 1'b0;
  bit            e_valid = 1'b0;
  logic [DW-1:0] e_data = '0;
  bit            e_data_known = 1'b1;

  always @(posedge clk or posedge rst) begin : model_step
    rd_t r;
    bit  wb;
    bit  fire;
    if (rst) begin
      m_front      = 1'b0;
      m_swapped    = 1'b0;
      m_hold       = 0;
      e_valid      = 1'b0;
      e_data       = '0;
      e_data_known = 1'b1;
      m_q.delete();
    end else begin
      m_cycle++;
      if (wr_en) begin
        wb = m_swapped ? m_front : !m_front;
        m_mem[wb][wr_addr]   = wr_data;
        m_known[wb][wr_addr] = 1'b1;
      end
      if (rd_en) begin
        r.due   = m_cycle + 2;
        r.val   = m_mem[m_front][rd_addr];
        r.known = m_known[m_front][rd_addr];
        m_q.push_back(r);
      end
      e_valid = 1'b0;
      if (m_q.size() > 0 && m_q[0].due == m_cycle) begin
        r            = m_q.pop_front();
        e_valid      = 1'b1;
        e_data       = r.val;
        e_data_known = r.known;
      end
      fire = (m_hold == 0) && full && frame_done;
      if (m_hold > 0) m_hold--;
      if (fire) begin
        m_hold  = 2;
        m_front = !m_front;
      end
      m_swapped = fire;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_output("cmp_front_bank", front_bank, m_front);
      check_output("cmp_swapped", swapped, m_swapped);
      check_output("cmp_rd_valid", rd_valid, e_valid);
      if (e_data_known) check_output("cmp_rd_data", rd_data, e_data);
    end
  end

  function automatic logic [DW-1:0] pat(input int tag, input int i);
    return (DW'(tag) << AW) | DW'(i);
  endfunction

  task automatic apply_stimulus(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input bit re, input logic [AW-1:0] ra, input bit fd);
    wr_en      = we;
    wr_addr    = wa;
    wr_data    = wd;
    rd_en      = re;
    rd_addr    = ra;
    frame_done = fd;
    @(negedge clk);
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    frame_done = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(0, '0, '0, 0, '0, 0);
  endtask

  task automatic do_swap();
    full = 1'b1;
    apply_stimulus(0, '0, '0, 0, '0, 1);
    full = 1'b0;
    idle_cycles(3);
  endtask

  initial begin : watchdog
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stimulus
    int n_valid;
    repeat (3) @(negedge clk);
    check_output("rst_front_bank", front_bank, 0);
    check_output("rst_swapped", swapped, 0);
    check_output("rst_rd_valid", rd_valid, 0);
    check_output("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    idle_cycles(2);

    // Write lands in back bank 1; the front bank 0 read does not see it.
    apply_stimulus(1, 14'd5, 20'hABCDE, 0, '0, 0);
    apply_stimulus(0, '0, '0, 1, 14'd5, 0);
    check_output("t1_lat_edge0", rd_valid, 0);
    idle_cycles(1);
    check_output("t1_lat_edge1", rd_valid, 0);
    idle_cycles(1);
    check_output("t1_valid", rd_valid, 1);
    check_output("t1_not_back_data", rd_data != 20'hABCDE, 1);

    // full waits for frame_done, then one swap pulse.
    full = 1'b1;
    idle_cycles(10);
    check_output("t2_waiting", swapped, 0);
    check_output("t2_front_before", front_bank, 0);
    apply_stimulus(0, '0, '0, 0, '0, 1);
    check_output("t2_swapped", swapped, 1);
    check_output("t2_front_after", front_bank, 1);
    full = 1'b0;
    idle_cycles(1);
    check_output("t2_pulse_width", swapped, 0);
    idle_cycles(2);
    apply_stimulus(0, '0, '0, 1, 14'd5, 0);
    idle_cycles(2);
    check_output("t2_read_valid", rd_valid, 1);
    check_output("t2_read_data", rd_data, 20'hABCDE);

    // full and frame_done together; later frame_done pulses are ignored.
    full = 1'b1;
    apply_stimulus(0, '0, '0, 0, '0, 1);
    check_output("t3_same_cycle", swapped, 1);
    full = 1'b0;
    apply_stimulus(0, '0, '0, 0, '0, 1);
    apply_stimulus(0, '0, '0, 0, '0, 1);
    check_output("t3_no_double", front_bank, 0);
    idle_cycles(2);

    // Read issued on the swap edge uses the old front bank.
    apply_stimulus(1, 14'd9, 20'h11111, 0, '0, 0);
    do_swap();
    apply_stimulus(1, 14'd9, 20'h22222, 0, '0, 0);
    full = 1'b1;
    apply_stimulus(0, '0, '0, 1, 14'd9, 1);
    check_output("t4_swapped", swapped, 1);
    full = 1'b0;
    apply_stimulus(1, 14'd10, 20'h33333, 1, 14'd9, 0);
    idle_cycles(1);
    check_output("t4_old_bank", rd_data, 20'h11111);
    idle_cycles(1);
    check_output("t4_new_bank", rd_data, 20'h22222);
    idle_cycles(2);
    apply_stimulus(0, '0, '0, 1, 14'd10, 0);
    idle_cycles(2);
    check_output("t4_swap_cycle_write", rd_data, 20'h33333);

    // Non-VSYNC instance swaps as soon as full is seen.
    full_nv = 1'b1;
    idle_cycles(1);
    check_output("t5_nv_swapped", swapped_nv, 1);
    check_output("t5_nv_front", front_bank_nv, 1);
    full_nv = 1'b0;
    idle_cycles(1);
    check_output("t5_nv_pulse_width", swapped_nv, 0);
    check_output("t5_nv_no_read", rd_valid_nv, 0);

    // Reset while waiting for vsync.
    do_swap();
    full = 1'b1;
    idle_cycles(3);
    check_output("t5_front_pre_rst", front_bank, 1);
    #2 rst = 1'b1;
    full = 1'b0;
    #1;
    check_output("t5_rst_front", front_bank, 0);
    check_output("t5_rst_swapped", swapped, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3);
    check_output("t5_no_pulse", swapped, 0);

    // Full-frame streams with continuous scan-out reads.
    for (int i = 0; i < DEPTH; i++) apply_stimulus(1, AW'(i), pat(1, i), 1, AW'(i), 0);
    idle_cycles(2);
    do_swap();
    n_valid = 0;
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(1, AW'(i), pat(2, i), 1, AW'(i), 0);
      if (rd_valid) n_valid++;
    end
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(0, '0, '0, 0, '0, 0);
      if (rd_valid) n_valid++;
    end
    check_output("t6_no_stall", n_valid, DEPTH);
    do_swap();
    apply_stimulus(0, '0, '0, 1, 14'd100, 0);
    idle_cycles(2);
    check_output("t6_frame_b_100", rd_data, 20'h08064);
    apply_stimulus(0, '0, '0, 1, 14'h3FFF, 0);
    idle_cycles(2);
    check_output("t6_frame_b_last", rd_data, 20'h0BFFF);
    idle_cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/framebuffer.md
Name: framebuffer

Overview:
Double-buffered pixel store that sits directly downstream of the USB/FTDI frame receiver, in the same clk_60 domain.
- Accepts 20-bit pixel writes (R7/G7/B6) into the back bank.
- Serves the panel scan-out from the front bank.
- Swaps the banks when the receiver reports a full frame and the display has finished its current frame.
- Returns a one-cycle swapped pulse that releases the receiver's full flag and resets its write counter.

Parameters:
ADDR_W, 14, pixel address width; each bank holds 2**ADDR_W words.
DATA_W, 20, pixel word width.
SWAP_ON_VSYNC, 1, 1 = swap only on frame_done; 0 = swap as soon as full is seen.

Ports:
clk  in  1  system clock (clk_60 domain)
rst  in  1  asynchronous, active-high reset
wr_data  in  DATA_W  pixel from receiver
wr_addr  in  ADDR_W  pixel address from receiver
wr_en  in  1  write strobe, one word per cycle
full  in  1  receiver has written the last pixel of a frame
swapped  out  1  one-cycle pulse: banks have been exchanged
frame_done  in  1  one-cycle pulse from scan-out at end of a displayed frame
rd_addr  in  ADDR_W  scan-out read address
rd_en  in  1  scan-out read request
rd_data  out  DATA_W  pixel read from the front bank
rd_valid  out  1  rd_data is valid
front_bank  out  1  index of the bank currently being displayed

Behaviour:
- Reset (asynchronous assert): front_bank=0, swapped=0, rd_valid=0, rd_data=0, FSM=IDLE. RAM contents are not reset.
- Write path:
  - When wr_en=1, write wr_data to bank (~front_bank) at wr_addr, using front_bank as registered at that same edge.
  - A write in the cycle swapped is asserted still lands in the old back bank.
  - Writes are never blocked or dropped.
- Read path:
  - 2-cycle latency: RAM read register, then output register.
  - rd_en at edge N gives rd_valid=1 and rd_data at edge N+2.
  - The bank index is captured together with rd_addr at edge N, so a read in flight across a swap returns data from the old front bank.
  - Back-to-back reads are allowed, one per cycle. rd_valid=0 otherwise; rd_data holds its last value.
- Swap FSM:
  - IDLE:
    - full=1 and (frame_done=1 or SWAP_ON_VSYNC=0) -> SWAP.
    - full=1 otherwise -> WAIT_VSYNC.
  - WAIT_VSYNC:
    - frame_done=1 -> SWAP.
    - Otherwise stay.
    - full deasserting here returns to IDLE with no swap.
  - SWAP: toggle front_bank and assert swapped=1 for exactly this cycle, then -> RELEASE.
  - RELEASE: ignore full for one cycle, because the receiver clears full on the edge after swapped; then -> IDLE.
  - The swap, swapped pulse and front_bank toggle are all registered. front_bank changes on the same edge swapped rises.
- Simultaneous events:
  - full and frame_done in the same cycle in IDLE: swap, with no extra frame of latency.
  - A frame_done pulse in SWAP or RELEASE is ignored.
- At most one swap per full assertion. full held high past RELEASE, because the receiver has a new frame, starts a new swap cycle.
- Reset mid-swap: FSM returns to IDLE, front_bank=0, no swapped pulse is emitted.
- Address width: 2**ADDR_W words per bank. Addresses are used unmodified, with no wrap logic internal to the block.

Decomposition:
- Package fb_pkg:
  - ADDR_W and DATA_W defaults.
  - Pixel field widths: R=7, G=7, B=6.
  - Swap FSM state encoding: IDLE, WAIT_VSYNC, SWAP, RELEASE.
- Sub-module fb_bank: simple dual-port RAM, one write port and one registered read port, inferred as block RAM. It is instantiated twice.
- The top level holds the FSM, bank steering, read pipeline and rd_data mux.

Test Plan:
1. Reset, then write 0xABCDE to bank 1 (front_bank=0) at address 5; read address 5 -> rd_valid at +2 cycles with data from bank 0, not 0xABCDE.
2. Pulse full, then frame_done 10 cycles later -> swapped=1 for exactly 1 cycle on the edge after frame_done; front_bank 0->1; reading address 5 now returns 0xABCDE at latency 2.
3. full and frame_done asserted in the same cycle in IDLE -> swapped on the next edge; a second frame_done in RELEASE causes no second toggle.
4. Issue rd_en at the cycle before the swap edge -> returned data comes from the old front bank; reads issued after the edge use the new bank.
5. SWAP_ON_VSYNC=0: full=1 with no frame_done -> swapped 1 cycle later. Assert rst during WAIT_VSYNC -> front_bank=0, no swapped pulse, FSM=IDLE.
6. Stream 16384 consecutive writes followed by full, with continuous reads during the stream -> every read matches the previous frame contents, with no read stalls.
